// File: rtl/md_unit_pkg.sv
// md_unit shared definitions: op codes, FSM state encoding, step count.
// Imported by md_unit and md_iter_core.
package md_unit_pkg;

  localparam int MD_STEPS = 32;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_iter_core.sv
// Shared radix-2 datapath: 2W-bit accumulator/remainder shift register
// plus one (W+1)-bit adder used as add (multiply) or subtract (divide).
// Ports: clk/resetn, load_i (latch a_i/b_i), step_i (one iteration),
// mul_i (1 = shift-add multiply, 0 = restoring divide), acc_o (state).
module md_iter_core
  import md_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           mul_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] acc_o
);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [W:0]     x, y;
  logic [W+1:0]   s;

  // Divide computes x - d as x + ~d + 1; s[W+1] is then the no-borrow bit.
  always_comb begin
    x = mul_i ? {1'b0, acc_q[2*W-1:W]} : acc_q[2*W-1:W-1];
    y = mul_i ? {1'b0, opnd_q} : ~{1'b0, opnd_q};
    s = {1'b0, x} + {1'b0, y} + {{(W+1){1'b0}}, ~mul_i};
  end

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    if (load_i) begin
      acc_d  = {{W{1'b0}}, a_i};
      opnd_d = b_i;
    end else if (step_i) begin
      if (mul_i) begin
        acc_d = acc_q[0] ? {s[W:0], acc_q[W-1:1]}
                         : {1'b0, acc_q[2*W-1:W], acc_q[W-1:1]};
      end else begin
        acc_d = s[W+1] ? {s[W-1:0], acc_q[W-2:0], 1'b1}
                       : {acc_q[2*W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit with HI/LO; sequencing FSM and sign fix.
// Ports: clk/resetn, op_valid/op_code/op_a/op_b, cancel, op_ready/busy, hi/lo.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            op_valid,
  input  logic [2:0]      op_code,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            cancel,
  output logic            op_ready,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic mul_q, mul_d;
  logic sq_q, sq_d;
  logic sr_q, sr_d;
  logic dbz_q, dbz_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;

  logic accept, is_md, is_mul, is_sgn;
  logic core_load, core_step, core_mul;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN-1:0] quo, rem;

  assign op_ready = (state_q == MD_IDLE);
  assign busy     = (state_q != MD_IDLE);
  assign accept   = op_valid & op_ready & ~cancel;

  always_comb begin
    is_md  = 1'b0;
    is_mul = 1'b0;
    is_sgn = 1'b0;
    unique case (1'b1)
      (op_code == MD_MULT):  begin is_md = 1'b1; is_mul = 1'b1; is_sgn = 1'b1; end
      (op_code == MD_MULTU): begin is_md = 1'b1; is_mul = 1'b1; end
      (op_code == MD_DIV):   begin is_md = 1'b1; is_sgn = 1'b1; end
      (op_code == MD_DIVU):  begin is_md = 1'b1; end
      default: ;
    endcase
  end

  // Magnitudes; the most negative value maps onto itself as unsigned.
  assign a_mag = (is_sgn && op_a[XLEN-1]) ? -op_a : op_a;
  assign b_mag = (is_sgn && op_b[XLEN-1]) ? -op_b : op_b;

  assign core_load = accept & is_md;
  assign core_step = (state_q == MD_RUN) & ~cancel;
  assign core_mul  = (state_q == MD_IDLE) ? is_mul : mul_q;

  md_iter_core #(.W(XLEN)) u_core (
    .clk    (clk),
    .resetn (resetn),
    .load_i (core_load),
    .step_i (core_step),
    .mul_i  (core_mul),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .acc_o  (acc)
  );

  always_comb begin
    prod = sq_q ? -acc : acc;
    quo  = sq_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = sr_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mul_d   = mul_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    dbz_d   = dbz_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      MD_IDLE: begin
        if (accept) begin
          if (is_md) begin
            state_d = MD_RUN;
            cnt_d   = '0;
            mul_d   = is_mul;
            sq_d    = is_sgn & (op_a[XLEN-1] ^ op_b[XLEN-1]);
            sr_d    = is_sgn & op_a[XLEN-1];
            dbz_d   = ~is_mul & (op_b == '0);
            a_d     = op_a;
          end else if (op_code == MD_MTHI) begin
            hi_d = op_a;
          end else if (op_code == MD_MTLO) begin
            lo_d = op_a;
          end
        end
      end
      MD_RUN: begin
        if (cancel) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(MD_STEPS - 1)) begin
            state_d = MD_FIX;
          end
        end
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        if (!cancel) begin
          if (mul_q) begin
            hi_d = prod[2*XLEN-1:XLEN];
            lo_d = prod[XLEN-1:0];
          end else if (dbz_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      dbz_q   <= 1'b0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_q   <= mul_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      dbz_q   <= dbz_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
